// File: rtl/dp_op_sequencer_if.sv
// Command/result handshake bundle between a client and dp_op_sequencer.
// master = command producer / result consumer, slave = the sequencer.
interface dp_op_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int REP_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_opcode;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [REP_W-1:0] cmd_rep;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_y;
  logic             res_co;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_rep, res_ready,
    input  cmd_ready, res_valid, res_y, res_co
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_rep, res_ready,
    output cmd_ready, res_valid, res_y, res_co
  );
endinterface

// File: rtl/dp_op_sequencer.sv
// Command-side sequencer for the 16-bit arithmetic datapath: issues an op, chains Y back
// into A for cmd_rep passes, returns the final Y/co. CO_STICKY_EN makes res_co the OR over all passes.
module dp_op_sequencer #(
  parameter int WIDTH  = 16,
  parameter int REP_W  = 4,
  parameter int DP_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  dp_op_sequencer_if.slave  bus,
  output logic [2:0]        dp_opcode,
  output logic [WIDTH-1:0]  dp_a,
  output logic [WIDTH-1:0]  dp_b,
  input  logic [WIDTH-1:0]  dp_y,
  input  logic              dp_co,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int LAT_W = (DP_LAT < 2) ? 1 : $clog2(DP_LAT + 1);

  logic [1:0]       state_r;
  logic [REP_W-1:0] pass_cnt_r;
  logic [LAT_W-1:0] wait_cnt_r;
  logic             carry_r;
  logic             carry_nxt_s;

  // Carry value to record for the pass completing this cycle.
  always_comb begin
    carry_nxt_s = dp_co;
`ifdef CO_STICKY_EN
    carry_nxt_s = carry_r | dp_co;
`else
    carry_nxt_s = dp_co;
`endif
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      pass_cnt_r    <= {REP_W{1'b0}};
      wait_cnt_r    <= {LAT_W{1'b0}};
      carry_r       <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_y     <= {WIDTH{1'b0}};
      bus.res_co    <= 1'b0;
      dp_opcode     <= 3'd0;
      dp_a          <= {WIDTH{1'b0}};
      dp_b          <= {WIDTH{1'b0}};
      busy          <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.cmd_valid) begin
            dp_opcode     <= bus.cmd_opcode;
            dp_a          <= bus.cmd_a;
            dp_b          <= bus.cmd_b;
            pass_cnt_r    <= (bus.cmd_rep == {REP_W{1'b0}}) ? REP_W'(1) : bus.cmd_rep;
            carry_r       <= 1'b0;
            bus.cmd_ready <= 1'b0;
            busy          <= 1'b1;
            state_r       <= ISSUE;
          end else begin
            state_r       <= IDLE;
          end
        end
        ISSUE: begin
          wait_cnt_r <= LAT_W'(DP_LAT);
          state_r    <= WAIT;
        end
        WAIT: begin
          // The pass completes on the edge where the wait counter reaches zero.
          if (wait_cnt_r > LAT_W'(1)) begin
            wait_cnt_r <= wait_cnt_r - LAT_W'(1);
          end else begin
            wait_cnt_r <= {LAT_W{1'b0}};
            pass_cnt_r <= pass_cnt_r - REP_W'(1);
            carry_r    <= carry_nxt_s;
            if (pass_cnt_r == REP_W'(1)) begin
              bus.res_y     <= dp_y;
              bus.res_co    <= carry_nxt_s;
              bus.res_valid <= 1'b1;
              state_r       <= RESP;
            end else begin
              dp_a          <= dp_y;
              state_r       <= ISSUE;
            end
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            busy          <= 1'b0;
            state_r       <= IDLE;
          end else begin
            state_r       <= RESP;
          end
        end
        default: begin
          bus.res_valid <= 1'b0;
          bus.cmd_ready <= 1'b1;
          busy          <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule
